proc_run_ctrl: RTL and testbench
================================

Name: proc_run_ctrl

Overview:
Synthesizable run controller between the board/bench and the processor core `top`. It does the following:
- stretches a start request into a multi-cycle core reset;
- runs the core under a cycle budget, in free-run or single-step mode;
- stops on budget expiry, a core halt or an external abort;
- registers the 16-bit data ports and reports cycle count and stop cause.

It replaces the fixed "reset 5 cycles, run 800 ns, stop" sequencing with a parametrised, on-chip block.

Parameters:
DATA_W, 16, width of din/dout paths
RST_CYCLES, 5, core reset stretch length in clk cycles (>=1)
CNT_W, 16, width of budget and cycle counter

Ports:
clk  in  1  system clock
sys_rst  in  1  synchronous, active-low reset
start  in  1  level/pulse; sampled in IDLE or DONE, begins a run
mode  in  2  00 budget run, 01 free run, 10 step; latched on start; 11 treated as 00
budget  in  CNT_W  enabled-cycle limit; latched on start
step  in  1  in step mode, one pulse = one enabled core cycle
abort  in  1  forces stop
halt_req  in  1  core halt indication
din_ext  in  DATA_W  external data to core
dout_core  in  DATA_W  core output data
core_rst_n  out  1  active-low reset to core
core_en  out  1  core clock enable
din_core  out  DATA_W  registered din_ext
dout_ext  out  DATA_W  dout_core captured on enabled cycles
dout_vld  out  1  one-cycle pulse, cycle after each enabled cycle
busy  out  1  high in RESET/RUN/STEP_WAIT/STEP_EXEC
done  out  1  high in DONE
halt_cause  out  2  0 NONE, 1 BUDGET, 2 HALT, 3 ABORT
cycles  out  CNT_W  enabled cycles in current run; saturates at all-ones

Behaviour:
- Reset (sys_rst=0 at posedge):
  - state IDLE; all outputs 0, including core_rst_n=0 and halt_cause=NONE.
  - Reset mid-run has the same effect and takes priority over every other input.
- IDLE: core_rst_n=0, core_en=0. start=1 -> RESET. On the same edge: latch mode and budget, clear cycles, set halt_cause=NONE, load reset counter with RST_CYCLES-1.
- RESET: core_rst_n=0 for exactly RST_CYCLES cycles. When the counter reaches 0:
  - if latched budget==0 and mode!=01 -> DONE, cause BUDGET, with zero enabled cycles;
  - otherwise -> RUN (mode 00/01) or STEP_WAIT (mode 10).
- RUN: core_rst_n=1, core_en=1. cycles increments each cycle.
  - Mode 00 leaves when cycles reaches budget, giving exactly `budget` enabled cycles, then -> DONE, cause BUDGET.
  - Mode 01 ignores the budget.
- STEP_WAIT: core_en=0. step=1 -> STEP_EXEC.
- STEP_EXEC: core_en=1 for one cycle, cycles+1, then -> STEP_WAIT, or -> DONE if budget is reached.
- halt_req=1 during an enabled cycle: that cycle counts, then -> DONE, cause HALT.
- abort=1 in any busy state -> DONE next edge, cause ABORT. abort in IDLE/DONE is ignored.
- Stop-cause priority on the same cycle: abort > halt_req > budget.
- DONE: core_rst_n=1 (core state held for inspection), core_en=0, done=1.
  - cycles and halt_cause are held.
  - start=1 restarts: -> RESET, with the same latching as from IDLE.
- Data paths:
  - din_core <= din_ext every cycle (1-cycle latency).
  - dout_ext <= dout_core on cycles with core_en=1, otherwise held.
  - dout_vld is core_en delayed one cycle.
- cycles saturates at 2^CNT_W-1 in free run and never wraps.
- Budget compare is unsigned, full CNT_W width.

Decomposition:
- Package proc_run_pkg holds:
  - state enum IDLE/RESET/RUN/STEP_WAIT/STEP_EXEC/DONE;
  - mode constants MODE_BUDGET/MODE_FREE/MODE_STEP;
  - cause constants CAUSE_NONE/BUDGET/HALT/ABORT.
- One sub-module, sat_counter (parametrised width; clear, enable, saturate), is used for cycles.
- The reset stretch counter is inline.

Test Plan:
- sys_rst=0 for 3 cycles -> all outputs 0, state IDLE. Release, start=1, mode 00, budget=80:
  - core_rst_n=0 for exactly 5 cycles;
  - core_en=1 for exactly 80 cycles;
  - then done=1, halt_cause=1, cycles=80.
- Mode 01, halt_req pulsed on the 37th enabled cycle -> done, halt_cause=2, cycles=37, dout_ext = dout_core value of that cycle.
- Mode 10, budget=3, step pulsed 5 times with gaps:
  - core_en is high for exactly 1 cycle per pulse;
  - DONE after the 3rd pulse, cycles=3, cause BUDGET;
  - pulses 4–5 are ignored.
- abort asserted in RESET -> DONE, cause 3, cycles=0. Abort and halt_req together during RUN -> cause 3.
- budget=0 in mode 00 -> DONE straight after reset with cycles=0, cause 1. Free run with CNT_W=4 for 20 cycles -> cycles holds at 15.
- sys_rst=0 mid-RUN -> next edge all outputs 0, IDLE. Restart from DONE via start -> the 5-cycle reset sequence repeats and cycles clears.

Source files
------------

// File: rtl/proc_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_pkg
// Description : Shared state, mode and stop-cause encodings for proc_run_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_run_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESET     = 3'd1,
      RUN       = 3'd2,
      STEP_WAIT = 3'd3,
      STEP_EXEC = 3'd4,
      DONE      = 3'd5
   } state_t;

   localparam logic [1:0] MODE_BUDGET = 2'b00;
   localparam logic [1:0] MODE_FREE   = 2'b01;
   localparam logic [1:0] MODE_STEP   = 2'b10;

   localparam logic [1:0] CAUSE_NONE   = 2'd0;
   localparam logic [1:0] CAUSE_BUDGET = 2'd1;
   localparam logic [1:0] CAUSE_HALT   = 2'd2;
   localparam logic [1:0] CAUSE_ABORT  = 2'd3;

   // The unused encoding 11 behaves as a budgeted run.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'b11) ? MODE_BUDGET : m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;
   logic             w_full;

   assign w_full = &r_count;
   assign count  = r_count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (en && !w_full) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_ctrl
// Description : Core run controller: reset stretch, budgeted/free/step runs,
//               stop-cause reporting and registered data ports.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_run_ctrl
   import proc_run_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int RST_CYCLES = 5,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  budget,
   input  logic              step,
   input  logic              abort,
   input  logic              halt_req,
   input  logic [DATA_W-1:0] din_ext,
   input  logic [DATA_W-1:0] dout_core,
   output logic              core_rst_n,
   output logic              core_en,
   output logic [DATA_W-1:0] din_core,
   output logic [DATA_W-1:0] dout_ext,
   output logic              dout_vld,
   output logic              busy,
   output logic              done,
   output logic [1:0]        halt_cause,
   output logic [CNT_W-1:0]  cycles
);

   localparam int c_RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [c_RST_W-1:0] c_RST_LOAD = c_RST_W'(RST_CYCLES - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          w_cause_nxt;
   logic                w_start_acc;
   logic                w_budget_hit;
   logic                w_rst;
   logic [1:0]          r_mode;
   logic [CNT_W-1:0]    r_budget;
   logic [c_RST_W-1:0]  r_rst_cnt;

   assign w_rst = ~sys_rst;

   // True when the enabled cycle now in progress is the last one the budget allows.
   assign w_budget_hit = (r_mode != MODE_FREE) &&
                         (({1'b0, cycles} + (CNT_W+1)'(1)) == {1'b0, r_budget});

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = halt_cause;
      w_start_acc = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt = RESET;
               w_cause_nxt = CAUSE_NONE;
               w_start_acc = 1'b1;
            end
         end
         RESET: begin
            if (abort) begin
               w_state_nxt = DONE;
               w_cause_nxt = CAUSE_ABORT;
            end else if (r_rst_cnt == '0) begin
               if ((r_budget == '0) && (r_mode != MODE_FREE)) begin
                  w_state_nxt = DONE;
                  w_cause_nxt = CAUSE_BUDGET;
               end else if (r_mode == MODE_STEP) begin
                  w_state_nxt = STEP_WAIT;
               end else begin
                  w_state_nxt = RUN;
               end
            end
         end
         RUN, STEP_EXEC: begin
            if (abort) begin
               w_state_nxt = DONE;
               w_cause_nxt = CAUSE_ABORT;
            end else if (halt_req) begin
               w_state_nxt = DONE;
               w_cause_nxt = CAUSE_HALT;
            end else if (w_budget_hit) begin
               w_state_nxt = DONE;
               w_cause_nxt = CAUSE_BUDGET;
            end else if (r_state == STEP_EXEC) begin
               w_state_nxt = STEP_WAIT;
            end
         end
         STEP_WAIT: begin
            if (abort) begin
               w_state_nxt = DONE;
               w_cause_nxt = CAUSE_ABORT;
            end else if (step) begin
               w_state_nxt = STEP_EXEC;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      core_rst_n = 1'b0;
      core_en    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         RESET: begin
            busy = 1'b1;
         end
         RUN, STEP_EXEC: begin
            core_rst_n = 1'b1;
            core_en    = 1'b1;
            busy       = 1'b1;
         end
         STEP_WAIT: begin
            core_rst_n = 1'b1;
            busy       = 1'b1;
         end
         DONE: begin
            core_rst_n = 1'b1;
            done       = 1'b1;
         end
         default: begin
            core_rst_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         r_mode     <= MODE_BUDGET;
         r_budget   <= '0;
         r_rst_cnt  <= '0;
         halt_cause <= CAUSE_NONE;
         din_core   <= '0;
         dout_ext   <= '0;
         dout_vld   <= 1'b0;
      end else begin
         din_core   <= din_ext;
         dout_vld   <= core_en;
         halt_cause <= w_cause_nxt;
         if (core_en) begin
            dout_ext <= dout_core;
         end
         if (w_start_acc) begin
            r_mode    <= norm_mode(mode);
            r_budget  <= budget;
            r_rst_cnt <= c_RST_LOAD;
         end else if ((r_state == RESET) && (r_rst_cnt != '0)) begin
            r_rst_cnt <= r_rst_cnt - c_RST_W'(1);
         end
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_cycles (
      .clk   (clk),
      .rst   (w_rst),
      .clr   (w_start_acc),
      .en    (core_en),
      .count (cycles)
   );

endmodule
`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_run_ctrl
// Description : Directed self-checking bench for proc_run_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_proc_run_ctrl;

   logic        clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [15:0] budget = '0;
   logic        step = 1'b0;
   logic        abort = 1'b0;
   logic        halt_req = 1'b0;
   logic [15:0] din_ext = '0;
   logic [15:0] dout_core = '0;

   logic        core_rst_n, core_en, dout_vld, busy, done;
   logic [15:0] din_core, dout_ext, cycles;
   logic [1:0]  halt_cause;

   logic        core_rst_n4, core_en4, dout_vld4, busy4, done4;
   logic [15:0] din_core4, dout_ext4;
   logic [3:0]  cycles4;
   logic [1:0]  halt_cause4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   proc_run_ctrl dut (
      .clk(clk), .sys_rst(sys_rst), .start(start), .mode(mode), .budget(budget),
      .step(step), .abort(abort), .halt_req(halt_req), .din_ext(din_ext),
      .dout_core(dout_core), .core_rst_n(core_rst_n), .core_en(core_en),
      .din_core(din_core), .dout_ext(dout_ext), .dout_vld(dout_vld), .busy(busy),
      .done(done), .halt_cause(halt_cause), .cycles(cycles)
   );

   proc_run_ctrl #(.DATA_W(16), .RST_CYCLES(5), .CNT_W(4)) dut4 (
      .clk(clk), .sys_rst(sys_rst), .start(start), .mode(mode), .budget(budget[3:0]),
      .step(step), .abort(abort), .halt_req(halt_req), .din_ext(din_ext),
      .dout_core(dout_core), .core_rst_n(core_rst_n4), .core_en(core_en4),
      .din_core(din_core4), .dout_ext(dout_ext4), .dout_vld(dout_vld4), .busy(busy4),
      .done(done4), .halt_cause(halt_cause4), .cycles(cycles4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [1:0] m, input logic [15:0] b);
      mode   = m;
      budget = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   // Steps until done, counting reset/enabled/valid cycles; drives dout_core
   // with 0x1000+n on the n-th enabled cycle and raises halt_req on cycle halt_at.
   task automatic run_until_done(input int max, input int halt_at,
                                 output int rst_lo, output int en_cnt, output int vld_cnt);
      logic ok;
      ok = 1'b0;
      rst_lo = 0; en_cnt = 0; vld_cnt = 0;
      for (int i = 0; i < max; i++) begin
         if (busy && !core_rst_n) rst_lo++;
         if (core_en) begin
            en_cnt++;
            dout_core = 16'h1000 + 16'(en_cnt);
            halt_req  = (en_cnt == halt_at);
         end else begin
            halt_req = 1'b0;
         end
         if (dout_vld) vld_cnt++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      halt_req = 1'b0;
      if (!ok) chk("timeout_done", done, 1);
   endtask

   task automatic wait_core_en(input int max);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (core_en) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) chk("timeout_en", core_en, 1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rstn"},  core_rst_n, 0);
      chk({tag, "_en"},    core_en, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_cause"}, halt_cause, 0);
      chk({tag, "_cyc"},   cycles, 0);
      chk({tag, "_vld"},   dout_vld, 0);
      chk({tag, "_dout"},  dout_ext, 0);
      chk({tag, "_din"},   din_core, 0);
   endtask

   initial begin
      int rl, ec, vc, en_p;

      // Power-on reset
      din_ext   = 16'hA5A5;
      dout_core = 16'h5A5A;
      repeat (3) tick();
      check_all_zero("por");
      sys_rst = 1'b1;
      din_ext = 16'h1234;
      tick();
      chk("din_lat", din_core, 16'h1234);

      // Budgeted run of 80
      start_run(2'b00, 16'd80);
      run_until_done(300, 0, rl, ec, vc);
      chk("b80_rst", rl, 5);
      chk("b80_en", ec, 80);
      chk("b80_vld", vc, 80);
      chk("b80_cause", halt_cause, 1);
      chk("b80_cyc", cycles, 80);
      chk("b80_dout", dout_ext, 16'h1000 + 16'd80);

      // Free run halted on the 37th enabled cycle, restarted from DONE
      start_run(2'b01, 16'd5);
      chk("hlt_cyc_clr", cycles, 0);
      run_until_done(300, 37, rl, ec, vc);
      chk("hlt_rst", rl, 5);
      chk("hlt_en", ec, 37);
      chk("hlt_cause", halt_cause, 2);
      chk("hlt_cyc", cycles, 37);
      chk("hlt_dout", dout_ext, 16'h1025);

      // Step mode, budget 3, five pulses
      start_run(2'b10, 16'd3);
      for (int i = 0; i < 20 && !core_rst_n; i++) tick();
      chk("stp_wait_en", core_en, 0);
      for (int p = 1; p <= 5; p++) begin
         en_p = 0;
         repeat (3) begin tick(); en_p += int'(core_en); end
         step = 1'b1;
         tick();
         en_p += int'(core_en);
         step = 1'b0;
         repeat (3) begin tick(); en_p += int'(core_en); end
         chk($sformatf("stp_en_p%0d", p), en_p, (p <= 3) ? 1 : 0);
      end
      chk("stp_done", done, 1);
      chk("stp_cyc", cycles, 3);
      chk("stp_cause", halt_cause, 1);

      // Abort during RESET
      start_run(2'b00, 16'd10);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abr_rst_done", done, 1);
      chk("abr_rst_cause", halt_cause, 3);
      chk("abr_rst_cyc", cycles, 0);

      // Abort and halt together in RUN: abort wins
      start_run(2'b01, 16'd10);
      wait_core_en(20);
      tick(); tick();
      abort = 1'b1;
      halt_req = 1'b1;
      tick();
      abort = 1'b0;
      halt_req = 1'b0;
      chk("abr_hlt_done", done, 1);
      chk("abr_hlt_cause", halt_cause, 3);

      // Zero budget: straight to DONE after reset; abort in DONE ignored
      start_run(2'b00, 16'd0);
      run_until_done(50, 0, rl, ec, vc);
      chk("b0_rst", rl, 5);
      chk("b0_en", ec, 0);
      chk("b0_cause", halt_cause, 1);
      chk("b0_cyc", cycles, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abr_done", done, 1);
      chk("idle_abr_cause", halt_cause, 1);

      // Mode 11 behaves as budgeted
      start_run(2'b11, 16'd2);
      run_until_done(50, 0, rl, ec, vc);
      chk("m11_en", ec, 2);
      chk("m11_cause", halt_cause, 1);

      // Free run 20 cycles: 4-bit counter saturates at 15
      start_run(2'b01, 16'd0);
      wait_core_en(20);
      repeat (19) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("sat_cyc16", cycles, 20);
      chk("sat_cyc4", cycles4, 15);
      chk("sat_cause4", halt_cause4, 3);

      // Reset mid-run, then restart from IDLE
      din_ext = 16'hBEEF;
      start_run(2'b00, 16'd50);
      wait_core_en(20);
      repeat (3) tick();
      sys_rst = 1'b0;
      tick();
      check_all_zero("mid");
      sys_rst = 1'b1;
      start_run(2'b00, 16'd4);
      chk("rs_cyc_clr", cycles, 0);
      run_until_done(50, 0, rl, ec, vc);
      chk("rs_rst", rl, 5);
      chk("rs_en", ec, 4);
      chk("rs_cyc", cycles, 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
